// File: rtl/mem_resp_pkg.sv
// Shared constants for the memory/IO responder slice.
// IO window decode and read/write encodings live here.
package mem_resp_pkg;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [15:0] IO_DATA_OFS = 16'h0000;
    localparam logic [15:0] IO_STAT_OFS = 16'h0004;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[17:16] == IO_BASE[17:16];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; used for the UART TX and RX paths.
// Push while full is accepted only when a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          push_ok,
    output logic          pop_ok
);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign count   = wr_q - rd_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (rst) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + (AW+1)'(1);
            if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        wr_q <= wr_d;
        rd_q <= rd_d;
        if (push_ok && !rst) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_responder.sv
// Byte RAM responder with optional UART IO window at 0x30000.
// Define MEM_RESPONDER_IO_EN to build the IO window, FIFOs and halt flag.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_ram_rw,
    input  logic [31:0] in_ram_address,
    input  logic [7:0]  in_ram_data,
    output logic [7:0]  out_ram_data,
    output logic        out_io_full,
    output logic        out_tx_valid,
    output logic [7:0]  out_tx_data,
    input  logic        in_tx_ready,
    input  logic        in_rx_valid,
    input  logic [7:0]  in_rx_data,
    output logic        out_halt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            ram_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            out_ram_data_q, out_ram_data_d;
    logic [7:0]            rd_byte;
    logic                  port_rd, port_wr, io_sel;

    assign ram_addr = in_ram_address[ADDR_WIDTH-1:0];
    assign port_rd  = rdy && !rst && (in_ram_rw == RW_READ);
    assign port_wr  = rdy && !rst && (in_ram_rw == RW_WRITE);

`ifdef MEM_RESPONDER_IO_EN
    logic [15:0]   io_ofs;
    logic          data_sel, stat_sel;
    logic          tx_push, tx_pop, tx_full, tx_empty, tx_push_ok, tx_pop_ok;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_count, tx_cnt_nxt;
    logic [CW-1:0] unused_rx_count;
    logic          unused_rx_push_ok, unused_rx_pop_ok, unused_addr;
    logic          io_full_q, io_full_d;
    logic          halt_q, halt_d;

    assign io_sel   = is_io_addr(in_ram_address);
    assign io_ofs   = in_ram_address[15:0];
    assign data_sel = io_sel && (io_ofs == IO_DATA_OFS);
    assign stat_sel = io_sel && (io_ofs == IO_STAT_OFS);

    assign tx_push = port_wr && data_sel;
    assign tx_pop  = !tx_empty && in_tx_ready;
    assign rx_push = in_rx_valid && !rx_full;
    assign rx_pop  = port_rd && data_sel;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(tx_push), .push_data(in_ram_data),
        .pop(tx_pop), .head(tx_head),
        .full(tx_full), .empty(tx_empty), .count(tx_count),
        .push_ok(tx_push_ok), .pop_ok(tx_pop_ok)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .push_data(in_rx_data),
        .pop(rx_pop), .head(rx_head),
        .full(rx_full), .empty(rx_empty), .count(unused_rx_count),
        .push_ok(unused_rx_push_ok), .pop_ok(unused_rx_pop_ok)
    );

    // Backpressure looks at the count after this edge, leaving one slot spare
    assign tx_cnt_nxt = tx_count + CW'(tx_push_ok) - CW'(tx_pop_ok);

    always_comb begin
        io_full_d = 1'b0;
        halt_d    = 1'b0;
        if (!rst) begin
            io_full_d = tx_cnt_nxt >= CW'(FIFO_DEPTH - 1);
            halt_d    = halt_q || (port_wr && stat_sel);
        end
    end

    always_ff @(posedge clk) begin
        io_full_q <= io_full_d;
        halt_q    <= halt_d;
    end

    assign rd_byte = !io_sel  ? ram_q[ram_addr] :
                     data_sel ? (rx_empty ? 8'h00 : rx_head) :
                     stat_sel ? {6'b0, !rx_empty, tx_full} :
                                8'h00;

    assign unused_addr  = ^in_ram_address[31:18];
    assign out_io_full  = io_full_q;
    assign out_tx_valid = !tx_empty;
    assign out_tx_data  = tx_head;
    assign out_halt     = halt_q;
`else
    logic unused_io;

    assign io_sel    = 1'b0;
    assign rd_byte   = ram_q[ram_addr];
    assign unused_io = ^{in_tx_ready, in_rx_valid, in_rx_data,
                         in_ram_address[31:ADDR_WIDTH]};

    assign out_io_full  = 1'b0;
    assign out_tx_valid = 1'b0;
    assign out_tx_data  = 8'h00;
    assign out_halt     = 1'b0;
`endif

    always_comb begin
        out_ram_data_d = out_ram_data_q;
        if (rst)          out_ram_data_d = 8'h00;
        else if (port_rd) out_ram_data_d = rd_byte;
    end

    always_ff @(posedge clk) begin
        out_ram_data_q <= out_ram_data_d;
        if (port_wr && !io_sel) ram_q[ram_addr] <= in_ram_data;
    end

    assign out_ram_data = out_ram_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a queue/array reference model.
module tb_mem_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, rdy, in_ram_rw, in_tx_ready, in_rx_valid;
    logic [31:0] in_ram_address;
    logic [7:0]  in_ram_data, in_rx_data;
    logic [7:0]  out_ram_data, out_tx_data;
    logic        out_io_full, out_tx_valid, out_halt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram_m [int];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [31:0] addr_list [$];
    logic [7:0]  exp_rd;
    bit          rd_known, halt_m, full_m;

    mem_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_ram_rw(in_ram_rw), .in_ram_address(in_ram_address),
        .in_ram_data(in_ram_data), .out_ram_data(out_ram_data),
        .out_io_full(out_io_full), .out_tx_valid(out_tx_valid),
        .out_tx_data(out_tx_data), .in_tx_ready(in_tx_ready),
        .in_rx_valid(in_rx_valid), .in_rx_data(in_rx_data),
        .out_halt(out_halt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic set_port(input logic rw, input logic [31:0] a, input logic [7:0] d);
        in_ram_rw      = rw;
        in_ram_address = a;
        in_ram_data    = d;
    endtask

    // Apply one rising edge and advance the reference model by the same step
    task automatic tick();
        bit          io, txpop, rxpop, rxroom;
        int          key;
        logic [15:0] ofs;
        logic [7:0]  v;
        key    = int'(in_ram_address[16:0]);
        io     = 1'b0;
`ifdef MEM_RESPONDER_IO_EN
        io     = in_ram_address[17:16] == 2'b11;
`endif
        ofs    = in_ram_address[15:0];
        txpop  = tx_q.size() > 0 && in_tx_ready;
        rxroom = rx_q.size() < DEPTH;
        rxpop  = 1'b0;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            halt_m   = 1'b0;
            full_m   = 1'b0;
            exp_rd   = 8'h00;
            rd_known = 1'b1;
        end else begin
            if (rdy && !in_ram_rw) begin
                if (io) begin
                    v = 8'h00;
                    if (ofs == 16'h0) begin
                        if (rx_q.size() > 0) begin
                            v = rx_q[0];
                            rxpop = 1'b1;
                        end
                    end else if (ofs == 16'h4) begin
                        v = {6'b0, rx_q.size() > 0, tx_q.size() == DEPTH};
                    end
                    exp_rd   = v;
                    rd_known = 1'b1;
                end else if (ram_m.exists(key)) begin
                    exp_rd   = ram_m[key];
                    rd_known = 1'b1;
                end else begin
                    rd_known = 1'b0;
                end
            end
            if (txpop) void'(tx_q.pop_front());
            if (rdy && in_ram_rw) begin
                if (!io) begin
                    ram_m[key] = in_ram_data;
                end else if (ofs == 16'h0) begin
                    if (tx_q.size() < DEPTH) tx_q.push_back(in_ram_data);
                end else if (ofs == 16'h4) begin
                    halt_m = 1'b1;
                end
            end
`ifdef MEM_RESPONDER_IO_EN
            if (rxpop) void'(rx_q.pop_front());
            if (in_rx_valid && rxroom) rx_q.push_back(in_rx_data);
`endif
            full_m = tx_q.size() >= DEPTH - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; in_tx_ready = 1'b0;
        in_rx_valid = 1'b0; in_rx_data = 8'h00;
        set_port(1'b0, 32'h0, 8'h00);
        tick();
        tick();
        checks++;
        if (out_ram_data !== 8'h00) begin
            errors++; $display("FAIL reset_rdata: got %h want 00", out_ram_data);
        end
        checks++;
        if (out_tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_tx_valid: got %b want 0", out_tx_valid);
        end
        checks++;
        if (out_io_full !== 1'b0) begin
            errors++; $display("FAIL reset_io_full: got %b want 0", out_io_full);
        end
        checks++;
        if (out_halt !== 1'b0) begin
            errors++; $display("FAIL reset_halt: got %b want 0", out_halt);
        end
        rst = 1'b0;
        set_port(1'b1, 32'h0, 8'h00);
        tick();
        set_port(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_ram_basic();
        set_port(1'b1, 32'h10, 8'hA5); tick();
        set_port(1'b0, 32'h10, 8'h00); tick();
        checks++;
        if (out_ram_data !== 8'hA5) begin
            errors++; $display("FAIL ram_basic: got %h want a5", out_ram_data);
        end
        set_port(1'b1, 32'h10, 8'h3C); tick();
        set_port(1'b0, 32'h10, 8'h00); tick();
        checks++;
        if (out_ram_data !== exp_rd || exp_rd !== 8'h3C) begin
            errors++; $display("FAIL ram_overwrite: got %h want 3c", out_ram_data);
        end
        set_port(1'b0, 32'h0, 8'h00);
        tick();
    endtask

    task automatic test_ram_random();
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if (addr_list.size() == 0 || $urandom_range(0, 1) == 1) begin
`ifdef MEM_RESPONDER_IO_EN
                a = 32'($urandom_range(0, 32'h1FFFF));
`else
                a = $urandom;
`endif
                if (rdy) addr_list.push_back(a);
                set_port(1'b1, a, 8'($urandom));
            end else begin
                a = addr_list[$urandom_range(0, addr_list.size() - 1)];
                set_port(1'b0, a, 8'h00);
            end
            tick();
            if (rd_known) begin
                checks++;
                if (out_ram_data !== exp_rd) begin
                    errors++;
                    $display("FAIL ram_random[%0d]: addr %h got %h want %h",
                             i, a, out_ram_data, exp_rd);
                end
            end
        end
        rdy = 1'b1;
        set_port(1'b0, 32'h0, 8'h00);
        tick();
    endtask

    task automatic test_rdy_low();
        set_port(1'b1, 32'h123, 8'h5C); tick();
        set_port(1'b0, 32'h123, 8'h00); tick();
        rdy = 1'b0;
        set_port(1'b1, 32'h123, 8'hEE); tick();
        set_port(1'b0, 32'h10, 8'h00); tick();
        checks++;
        if (out_ram_data !== 8'h5C) begin
            errors++; $display("FAIL rdy_hold: got %h want 5c", out_ram_data);
        end
        rdy = 1'b1;
        set_port(1'b0, 32'h123, 8'h00); tick();
        checks++;
        if (out_ram_data !== exp_rd || exp_rd !== 8'h5C) begin
            errors++; $display("FAIL rdy_no_write: got %h want 5c", out_ram_data);
        end
        set_port(1'b0, 32'h0, 8'h00);
    endtask

`ifndef MEM_RESPONDER_IO_EN
    task automatic test_alias();
        in_tx_ready = 1'b1;
        in_rx_valid = 1'b1; in_rx_data = 8'h99;
        set_port(1'b1, 32'h30000, 8'h77); tick();
        checks++;
        if (out_tx_valid !== 1'b0) begin
            errors++; $display("FAIL alias_tx_valid: got %b want 0", out_tx_valid);
        end
        set_port(1'b1, 32'h30004, 8'h11); tick();
        set_port(1'b0, 32'h10000, 8'h00); tick();
        checks++;
        if (out_ram_data !== 8'h77) begin
            errors++; $display("FAIL alias_data: got %h want 77", out_ram_data);
        end
        set_port(1'b0, 32'h10004, 8'h00); tick();
        checks++;
        if (out_ram_data !== 8'h11) begin
            errors++; $display("FAIL alias_stat: got %h want 11", out_ram_data);
        end
        checks++;
        if (out_halt !== 1'b0 || out_io_full !== 1'b0 || out_tx_data !== 8'h00) begin
            errors++;
            $display("FAIL alias_tied: halt %b full %b txd %h want 0 0 00",
                     out_halt, out_io_full, out_tx_data);
        end
        in_rx_valid = 1'b0;
        set_port(1'b0, 32'h0, 8'h00);
    endtask
`else
    task automatic test_tx_order();
        in_tx_ready = 1'b1;
        set_port(1'b1, 32'h30000, 8'h41); tick();
        checks++;
        if (out_tx_valid !== 1'b1 || out_tx_data !== 8'h41) begin
            errors++; $display("FAIL tx_first: valid %b data %h want 1 41", out_tx_valid, out_tx_data);
        end
        set_port(1'b1, 32'h30000, 8'h42); tick();
        checks++;
        if (out_tx_valid !== 1'b1 || out_tx_data !== 8'h42) begin
            errors++; $display("FAIL tx_second: valid %b data %h want 1 42", out_tx_valid, out_tx_data);
        end
        set_port(1'b0, 32'h0, 8'h00); tick();
        checks++;
        if (out_tx_valid !== 1'b0) begin
            errors++; $display("FAIL tx_drain: valid %b want 0", out_tx_valid);
        end
    endtask

    task automatic test_tx_full();
        int n;
        in_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_port(1'b1, 32'h30000, 8'h80 + 8'(i));
            tick();
            if (i == 5 || i == 6) begin
                checks++;
                if (out_io_full !== (i == 6)) begin
                    errors++;
                    $display("FAIL tx_io_full[%0d]: got %b want %b", i, out_io_full, i == 6);
                end
            end
        end
        set_port(1'b0, 32'h30004, 8'h00); tick();
        checks++;
        if (out_ram_data !== 8'h01) begin
            errors++; $display("FAIL tx_full_status: got %h want 01", out_ram_data);
        end
        set_port(1'b0, 32'h0, 8'h00);
        in_tx_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && out_tx_valid; c++) begin
            checks++;
            if (out_tx_data !== tx_q[0]) begin
                errors++; $display("FAIL tx_drain_data[%0d]: got %h want %h", n, out_tx_data, tx_q[0]);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 8 || out_tx_valid !== 1'b0 || out_io_full !== 1'b0) begin
            errors++;
            $display("FAIL tx_drain_count: got %0d bytes valid %b full %b want 8 0 0",
                     n, out_tx_valid, out_io_full);
        end
    endtask

    task automatic test_rx();
        in_rx_valid = 1'b1; in_rx_data = 8'h5A;
        set_port(1'b0, 32'h0, 8'h00); tick();
        in_rx_valid = 1'b0;
        set_port(1'b0, 32'h30004, 8'h00); tick();
        checks++;
        if (out_ram_data !== 8'h02) begin
            errors++; $display("FAIL rx_status: got %h want 02", out_ram_data);
        end
        set_port(1'b0, 32'h30000, 8'h00); tick();
        checks++;
        if (out_ram_data !== 8'h5A) begin
            errors++; $display("FAIL rx_data: got %h want 5a", out_ram_data);
        end
        tick();
        checks++;
        if (out_ram_data !== 8'h00) begin
            errors++; $display("FAIL rx_empty: got %h want 00", out_ram_data);
        end
        set_port(1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_halt_reset();
        set_port(1'b1, 32'h30004, 8'h00); tick();
        set_port(1'b0, 32'h0, 8'h00); tick(); tick();
        checks++;
        if (out_halt !== 1'b1) begin
            errors++; $display("FAIL halt_sticky: got %b want 1", out_halt);
        end
        in_tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_port(1'b1, 32'h30000, 8'($urandom)); tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        set_port(1'b0, 32'h0, 8'h00);
        checks++;
        if (out_tx_valid !== 1'b0 || out_halt !== 1'b0 || out_io_full !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_burst: valid %b halt %b full %b want 0 0 0",
                     out_tx_valid, out_halt, out_io_full);
        end
        tick();
    endtask

    task automatic test_io_random();
        int op;
        for (int i = 0; i < 400; i++) begin
            rdy         = ($urandom_range(0, 4) != 0);
            in_tx_ready = ($urandom_range(0, 2) == 0);
            in_rx_valid = ($urandom_range(0, 1) == 1);
            in_rx_data  = 8'($urandom);
            op = $urandom_range(0, 7);
            case (op)
                0: set_port(1'b1, 32'($urandom_range(0, 32'h1FFFF)), 8'($urandom));
                1: set_port(1'b0, addr_list[$urandom_range(0, addr_list.size() - 1)], 8'h00);
                2, 3: set_port(1'b1, 32'h30000, 8'($urandom));
                4, 5: set_port(1'b0, 32'h30000, 8'h00);
                6: set_port(1'b0, 32'h30004, 8'h00);
                default: set_port($urandom_range(0, 1) == 1, 32'h30008, 8'($urandom));
            endcase
            if (op == 0 && rdy) addr_list.push_back(in_ram_address);
            tick();
            if (rd_known) begin
                checks++;
                if (out_ram_data !== exp_rd) begin
                    errors++; $display("FAIL io_rand_rdata[%0d]: got %h want %h", i, out_ram_data, exp_rd);
                end
            end
            checks++;
            if (out_tx_valid !== (tx_q.size() > 0) || out_io_full !== full_m) begin
                errors++;
                $display("FAIL io_rand_flags[%0d]: valid %b full %b want %b %b",
                         i, out_tx_valid, out_io_full, tx_q.size() > 0, full_m);
            end
            if (tx_q.size() > 0) begin
                checks++;
                if (out_tx_data !== tx_q[0]) begin
                    errors++; $display("FAIL io_rand_txdata[%0d]: got %h want %h", i, out_tx_data, tx_q[0]);
                end
            end
        end
        rdy = 1'b1; in_rx_valid = 1'b0;
        set_port(1'b0, 32'h0, 8'h00);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_ram_basic();
        test_ram_random();
        test_rdy_low();
`ifndef MEM_RESPONDER_IO_EN
        test_alias();
`else
        test_tx_order();
        test_tx_full();
        test_rx();
        test_halt_reset();
        test_io_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
